// File: rtl/sqr_seq_if.sv
// Start/busy/done handshake and result bundle for the iterative squarer sqr_seq.
interface sqr_seq_if #(
  parameter int WIDTH = 26
);
  localparam int SW = $clog2(2 * WIDTH);

  logic             start;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [SW-1:0]    norm_shift;
  logic             sticky;
  logic             ovf;

  modport master (
    output start, in,
    input  busy, done, out, norm_shift, sticky, ovf
  );

  modport slave (
    input  start, in,
    output busy, done, out, norm_shift, sticky, ovf
  );
endinterface

// File: rtl/sqr_seq.sv
// Iterative shift-add squarer with left normalization, shift count and sticky bit.
// Define SQR_ROUND_EN for round-to-nearest-even on out (with ovf); default build truncates.
module sqr_seq #(
  parameter int WIDTH = 26
) (
  input  logic      clk,
  input  logic      rst,
  sqr_seq_if.slave  bus
);
  localparam int SW = $clog2(2 * WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_NORM, S_DONE} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] op_r;
  logic [WIDTH-1:0] mult_r;
  logic [PW-1:0]    acc_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] out_r;
  logic [SW-1:0]    norm_shift_r;
  logic             sticky_r;
  logic             ovf_r;

  logic [PW:0]      sum_s;
  logic [PW-1:0]    acc_nxt_s;
  logic [SW-1:0]    lz_s;
  logic [PW-1:0]    norm_s;
  logic [WIDTH-1:0] out_nxt_s;
  logic             sticky_nxt_s;
  logic             ovf_nxt_s;
`ifdef SQR_ROUND_EN
  logic             guard_s;
  logic             rest_s;
  logic             up_s;
  logic [WIDTH:0]   rnd_s;
`endif

  // Leading-zero count; an all-zero product reports 0 so zero needs no special state.
  function automatic logic [SW-1:0] lzc(input logic [PW-1:0] p);
    logic [SW-1:0] n;
    n = {SW{1'b0}};
    for (int i = 0; i < PW; i++) begin
      if (p[i]) begin
        n = SW'(PW - 1 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Shift-add step and normalization/rounding of the finished product.
  always_comb begin
    sum_s     = {1'b0, acc_r} + (mult_r[0] ? {1'b0, op_r, {WIDTH{1'b0}}} : {(PW+1){1'b0}});
    acc_nxt_s = PW'(sum_s >> 1);
    lz_s      = lzc(acc_r);
    norm_s    = acc_r << lz_s;
`ifdef SQR_ROUND_EN
    guard_s      = norm_s[WIDTH-1];
    rest_s       = |norm_s[WIDTH-2:0];
    up_s         = guard_s & (rest_s | norm_s[WIDTH]);
    rnd_s        = {1'b0, norm_s[PW-1:WIDTH]} + {{WIDTH{1'b0}}, up_s};
    sticky_nxt_s = guard_s | rest_s;
    if (rnd_s[WIDTH]) begin
      out_nxt_s = {1'b1, {(WIDTH-1){1'b0}}};
      ovf_nxt_s = 1'b1;
    end else begin
      out_nxt_s = rnd_s[WIDTH-1:0];
      ovf_nxt_s = 1'b0;
    end
`else
    out_nxt_s    = norm_s[PW-1:WIDTH];
    sticky_nxt_s = |norm_s[WIDTH-1:0];
    ovf_nxt_s    = 1'b0;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      op_r         <= {WIDTH{1'b0}};
      mult_r       <= {WIDTH{1'b0}};
      acc_r        <= {PW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      out_r        <= {WIDTH{1'b0}};
      norm_shift_r <= {SW{1'b0}};
      sticky_r     <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          // The cycle done is high still counts as busy, so start is not taken then.
          if (bus.start && !done_r) begin
            op_r    <= bus.in;
            mult_r  <= bus.in;
            acc_r   <= {PW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= S_RUN;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_RUN: begin
          acc_r  <= acc_nxt_s;
          mult_r <= mult_r >> 1;
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= S_NORM;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_NORM: begin
          out_r        <= out_nxt_s;
          norm_shift_r <= lz_s;
          sticky_r     <= sticky_nxt_s;
          ovf_r        <= ovf_nxt_s;
          state_r      <= S_DONE;
        end
        S_DONE: begin
          done_r  <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.out        = out_r;
  assign bus.norm_shift = norm_shift_r;
  assign bus.sticky     = sticky_r;
  assign bus.ovf        = ovf_r;
endmodule

// File: tb/tb_sqr_seq.sv
// Directed self-checking bench for sqr_seq (WIDTH=26, default truncating build).
module tb_sqr_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  sqr_seq_if #(.WIDTH(26)) bus ();

  sqr_seq #(.WIDTH(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for idle, pulse start with v, and return cycles from accepting edge to done.
  task automatic issue(input logic [25:0] v, output int lat);
    int g;
    g = 0;
    while (bus.busy && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in    = 26'h155AAAA;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_rise: got %b want 1", bus.busy);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 26'h0 ||
        bus.norm_shift !== 6'd0 || bus.sticky !== 1'b0 || bus.ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b out=%h ns=%0d sticky=%b ovf=%b want all 0",
               bus.busy, bus.done, bus.out, bus.norm_shift, bus.sticky, bus.ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 26'h0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b out=%h want 0 0 0", bus.busy, bus.done, bus.out);
    end
  endtask

  task automatic test_vectors();
    logic [25:0] vin [4];
    logic [25:0] vout[4];
    logic [5:0]  vns [4];
    logic        vst [4];
    int          lat;
    vin[0] = 26'h2000000; vout[0] = 26'h2000000; vns[0] = 6'd1;  vst[0] = 1'b0;
    vin[1] = 26'h0000003; vout[1] = 26'h2400000; vns[1] = 6'd48; vst[1] = 1'b0;
    vin[2] = 26'h3FFFFFF; vout[2] = 26'h3FFFFFE; vns[2] = 6'd0;  vst[2] = 1'b1;
    vin[3] = 26'h0002001; vout[3] = 26'h2002000; vns[3] = 6'd25; vst[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(vin[i], lat);
      total++;
      if (lat !== 28) begin
        bad++;
        $display("FAIL latency[%0d]: got %0d want 28", i, lat);
      end
      total++;
      if (bus.out !== vout[i] || bus.norm_shift !== vns[i] || bus.sticky !== vst[i] || bus.ovf !== 1'b0) begin
        bad++;
        $display("FAIL result[%0d]: out=%h ns=%0d sticky=%b ovf=%b want %h %0d %b 0",
                 i, bus.out, bus.norm_shift, bus.sticky, bus.ovf, vout[i], vns[i], vst[i]);
      end
      @(posedge clk); #1;
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out !== vout[i]) begin
        bad++;
        $display("FAIL after_done[%0d]: done=%b busy=%b out=%h want 0 0 %h",
                 i, bus.done, bus.busy, bus.out, vout[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = 26'h2000000;
    @(posedge clk); #1;
    bus.in = 26'h0000003;
    w = 0;
    while (bus.done !== 1'b1 && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    total++;
    if (bus.done !== 1'b1 || bus.out !== 26'h2000000 || bus.norm_shift !== 6'd1) begin
      bad++;
      $display("FAIL b2b_first: done=%b out=%h ns=%0d want 1 2000000 1", bus.done, bus.out, bus.norm_shift);
    end
    @(posedge clk); #1;
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_single_pulse: done=%b want 0", bus.done);
    end
    w = 0;
    while (!(bus.busy === 1'b1 && bus.done === 1'b0) && w < 5) begin
      @(posedge clk); #1;
      w++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    w = 0;
    while (bus.done !== 1'b1 && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    total++;
    if (bus.done !== 1'b1 || bus.out !== 26'h2400000 || bus.norm_shift !== 6'd48) begin
      bad++;
      $display("FAIL b2b_second: done=%b out=%h ns=%0d want 1 2400000 48", bus.done, bus.out, bus.norm_shift);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    int ndone;
    int g;
    g = 0;
    while (bus.busy && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = 26'h3FFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 26'h0 ||
        bus.norm_shift !== 6'd0 || bus.sticky !== 1'b0 || bus.ovf !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: busy=%b done=%b out=%h ns=%0d sticky=%b ovf=%b want all 0",
               bus.busy, bus.done, bus.out, bus.norm_shift, bus.sticky, bus.ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL midrun_no_done: got %0d pulses want 0", ndone);
    end
    issue(26'h0000003, lat);
    total++;
    if (lat !== 28 || bus.out !== 26'h2400000 || bus.norm_shift !== 6'd48) begin
      bad++;
      $display("FAIL post_reset_op: lat=%0d out=%h ns=%0d want 28 2400000 48", lat, bus.out, bus.norm_shift);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_ignore();
    int ndone;
    logic busy_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = 26'h0;
    @(posedge clk); #1;
    ndone   = 0;
    busy_ok = 1'b1;
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.start = (i == 5);
      bus.in    = (i == 5) ? 26'h0000003 : 26'h0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
      if ((ndone == 0 || bus.done === 1'b1) && bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    total++;
    if (ndone !== 1) begin
      bad++;
      $display("FAIL zero_done_count: got %0d want 1", ndone);
    end
    total++;
    if (busy_ok !== 1'b1) begin
      bad++;
      $display("FAIL zero_busy_held: got %b want 1", busy_ok);
    end
    total++;
    if (bus.out !== 26'h0 || bus.norm_shift !== 6'd0 || bus.sticky !== 1'b0) begin
      bad++;
      $display("FAIL zero_result: out=%h ns=%0d sticky=%b want 0 0 0", bus.out, bus.norm_shift, bus.sticky);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.in    = 26'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_zero_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
